// File: rtl/vga_sync_decoder.sv
// vga_sync_decoder: receive-side timing checker for a 640x480 style stream.
// Registers the incoming hsync/vsync/de, measures line and frame lengths,
// locks after LOCK_FRAMES consecutive good frames and regenerates pixel
// coordinates for downstream logic.
// Optional build macro VGA_SYNC_DECODER_STATS_EN adds the measurement and
// error-count outputs h_meas_o, v_meas_o and err_cnt.
module vga_sync_decoder #(
   parameter int   H_ACTIVE    = 640,
   parameter int   H_TOTAL     = 800,
   parameter int   V_ACTIVE    = 480,
   parameter int   V_TOTAL     = 525,
   parameter logic SYNC_POL    = 1'b0,
   parameter int   LOCK_FRAMES = 2
) (
   input  logic        clk_pix,
   input  logic        rst_pix,
   input  logic        hsync,
   input  logic        vsync,
   input  logic        de,
   output logic        rx_de,
   output logic [15:0] rx_x,
   output logic [15:0] rx_y,
   output logic        rx_frame,
   output logic        locked,
   output logic        err
`ifdef VGA_SYNC_DECODER_STATS_EN
   ,
   output logic [15:0] h_meas_o,
   output logic [15:0] v_meas_o,
   output logic [15:0] err_cnt
`endif
);

   localparam logic [15:0] H_TOTAL_C  = 16'(H_TOTAL);
   localparam logic [15:0] H_LAST_C   = 16'(H_ACTIVE - 1);
   localparam logic [15:0] V_ACTIVE_C = 16'(V_ACTIVE);
   localparam logic [15:0] V_TOTAL_C  = 16'(V_TOTAL);
   localparam logic [3:0]  LOCK_C     = 4'(LOCK_FRAMES);

   typedef enum logic [1:0] {SEARCH, ALIGN, LOCKED} state_t;

   state_t      state, state_nx;
   logic [3:0]  good, good_nx, good_inc;
   logic        err_nx;

   logic        hsync_q, hsync_qq, vsync_q, vsync_qq, de_q, de_qq;
   logic        hs_edge, vs_edge, de_rise, de_fall;
   logic [15:0] h_cnt, v_cnt, h_new, v_new;
   logic        h_valid, line_bad;
   logic        h_bad, x_over, y_over, line_mis, frame_bad;

   function automatic logic [15:0] sat_inc(input logic [15:0] v);
      return (v == 16'hFFFF) ? v : v + 16'd1;
   endfunction

   // Input register plus one delayed copy; edges come from comparing the two
   always_ff @(posedge clk_pix) begin
      if (rst_pix) begin
         hsync_q  <= ~SYNC_POL;
         hsync_qq <= ~SYNC_POL;
         vsync_q  <= ~SYNC_POL;
         vsync_qq <= ~SYNC_POL;
         de_q     <= 1'b0;
         de_qq    <= 1'b0;
      end else begin
         hsync_q  <= hsync;
         hsync_qq <= hsync_q;
         vsync_q  <= vsync;
         vsync_qq <= vsync_q;
         de_q     <= de;
         de_qq    <= de_q;
      end
   end

   assign hs_edge  = (hsync_q == SYNC_POL) && (hsync_qq != SYNC_POL);
   assign vs_edge  = (vsync_q == SYNC_POL) && (vsync_qq != SYNC_POL);
   assign de_rise  = de_q & ~de_qq;
   assign de_fall  = ~de_q & de_qq;

   // Candidate measurements; the hsync edge of this cycle belongs to the
   // frame that is closing so the frame length is phase independent
   assign h_new    = sat_inc(h_cnt);
   assign v_new    = hs_edge ? sat_inc(v_cnt) : v_cnt;
   assign good_inc = good + 4'd1;

   assign h_bad     = hs_edge && h_valid && (h_new != H_TOTAL_C);
   assign x_over    = de_q && !de_rise && (rx_x >= H_LAST_C);
   assign y_over    = de_rise && !vs_edge && (rx_y >= V_ACTIVE_C);
   assign line_mis  = h_bad || x_over || y_over;
   assign frame_bad = line_bad || line_mis || (v_new != V_TOTAL_C);

   // Line/frame counters and the sticky per-frame line error flag
   always_ff @(posedge clk_pix) begin
      if (rst_pix) begin
         h_cnt    <= 16'd0;
         v_cnt    <= 16'd0;
         h_valid  <= 1'b0;
         line_bad <= 1'b0;
      end else begin
         h_cnt <= hs_edge ? 16'd0 : h_new;
         v_cnt <= vs_edge ? 16'd0 : v_new;
         if (hs_edge)
            h_valid <= 1'b1;
         if (vs_edge)
            line_bad <= 1'b0;
         else if (line_mis)
            line_bad <= 1'b1;
      end
   end

   // Regenerated coordinates and frame pulse, two clocks behind the inputs
   always_ff @(posedge clk_pix) begin
      if (rst_pix) begin
         rx_de    <= 1'b0;
         rx_x     <= 16'd0;
         rx_y     <= 16'd0;
         rx_frame <= 1'b0;
      end else begin
         rx_de    <= de_q;
         rx_frame <= vs_edge;
         if (de_rise)
            rx_x <= 16'd0;
         else if (de_q)
            rx_x <= sat_inc(rx_x);
         if (vs_edge)
            rx_y <= 16'd0;
         else if (de_fall)
            rx_y <= sat_inc(rx_y);
      end
   end

   // Lock state register, good-frame counter and registered error pulse
   always_ff @(posedge clk_pix) begin
      if (rst_pix) begin
         state <= SEARCH;
         good  <= 4'd0;
         err   <= 1'b0;
      end else begin
         state <= state_nx;
         good  <= good_nx;
         err   <= err_nx;
      end
   end

   // Lock decisions: frames are judged at vsync, lines as soon as they break
   always_comb begin
      state_nx = state;
      good_nx  = good;
      err_nx   = 1'b0;
      case (state)
         SEARCH: begin
            if (vs_edge) begin
               state_nx = ALIGN;
               good_nx  = 4'd0;
            end
         end
         ALIGN: begin
            if (vs_edge) begin
               if (!frame_bad) begin
                  good_nx = good_inc;
                  if (good_inc >= LOCK_C)
                     state_nx = LOCKED;
               end else begin
                  good_nx = 4'd0;
               end
            end
         end
         LOCKED: begin
            if (line_mis || (vs_edge && frame_bad)) begin
               err_nx   = 1'b1;
               state_nx = ALIGN;
               good_nx  = 4'd0;
            end
         end
         default: begin
            state_nx = SEARCH;
            good_nx  = 4'd0;
         end
      endcase
   end

   assign locked = (state == LOCKED);

`ifdef VGA_SYNC_DECODER_STATS_EN
   // Last captured line/frame lengths and a saturating error pulse count
   always_ff @(posedge clk_pix) begin
      if (rst_pix) begin
         h_meas_o <= 16'd0;
         v_meas_o <= 16'd0;
         err_cnt  <= 16'd0;
      end else begin
         if (hs_edge)
            h_meas_o <= h_new;
         if (vs_edge)
            v_meas_o <= v_new;
         if (err)
            err_cnt <= sat_inc(err_cnt);
      end
   end
`endif

endmodule

// File: tb/tb_vga_sync_decoder.sv
// tb_vga_sync_decoder: directed bench for vga_sync_decoder using a shrunken
// raster (8x4 active, 12 clocks per line, 6 lines per frame, active-low syncs)
// so that lock, loss of lock and relock all fit in a short run.
module tb_vga_sync_decoder;

   localparam int HA = 8;
   localparam int HT = 12;
   localparam int VA = 4;
   localparam int VT = 6;

   logic        clk_pix = 1'b0;
   logic        rst_pix;
   logic        hsync, vsync, de;
   logic        rx_de, rx_frame, locked, err;
   logic [15:0] rx_x, rx_y;
`ifdef VGA_SYNC_DECODER_STATS_EN
   logic [15:0] h_meas_o, v_meas_o, err_cnt;
`endif

   int checks = 0;
   int passed = 0;
   int fails  = 0;

   int mon_en = 0;
   int err_seen = 0, frames_seen = 0, rise_seen = 0;
   int de_bad = 0, fr_bad = 0, xy_bad = 0, errlock_bad = 0, rise_bad = 0;
   int max_x = 0, max_y = 0;
   int e0;
   logic prev_locked = 1'b0;

   logic [35:0] snap;
   logic        pre_locked;

   logic        d1, d2, vd1, vd2, fr_m;
   logic [15:0] x_m, y_m;

   vga_sync_decoder #(
      .H_ACTIVE(HA), .H_TOTAL(HT), .V_ACTIVE(VA), .V_TOTAL(VT),
      .SYNC_POL(1'b0), .LOCK_FRAMES(2)
   ) dut (
      .clk_pix (clk_pix),
      .rst_pix (rst_pix),
      .hsync   (hsync),
      .vsync   (vsync),
      .de      (de),
      .rx_de   (rx_de),
      .rx_x    (rx_x),
      .rx_y    (rx_y),
      .rx_frame(rx_frame),
      .locked  (locked),
      .err     (err)
`ifdef VGA_SYNC_DECODER_STATS_EN
      ,
      .h_meas_o(h_meas_o),
      .v_meas_o(v_meas_o),
      .err_cnt (err_cnt)
`endif
   );

   always #5 clk_pix = ~clk_pix;

   // Reference view of the outputs: inputs delayed two clocks, x counted
   // along each de run, y cleared by vsync and advanced per finished line
   always @(posedge clk_pix) begin
      if (rst_pix) begin
         d1 <= 1'b0; d2 <= 1'b0; vd1 <= 1'b1; vd2 <= 1'b1;
         fr_m <= 1'b0; x_m <= 16'd0; y_m <= 16'd0;
      end else begin
         d1   <= de;
         d2   <= d1;
         vd1  <= vsync;
         vd2  <= vd1;
         fr_m <= !vd1 && vd2;
         x_m  <= (d1 && !d2) ? 16'd0 : (d1 ? x_m + 16'd1 : x_m);
         y_m  <= (!vd1 && vd2) ? 16'd0 : ((!d1 && d2) ? y_m + 16'd1 : y_m);
      end
   end

   // Observe outputs on the falling edge and tally events/discrepancies
   always @(negedge clk_pix) begin
      if (mon_en != 0) begin
         if (rx_de !== d2) de_bad++;
         if (rx_frame !== fr_m) fr_bad++;
         if (rx_de && (rx_x !== x_m || rx_y !== y_m)) xy_bad++;
         if (rx_de && int'(rx_x) > max_x) max_x = int'(rx_x);
         if (rx_de && int'(rx_y) > max_y) max_y = int'(rx_y);
         if (rx_frame) frames_seen++;
         if (err) begin
            err_seen++;
            if (!(prev_locked && !locked)) errlock_bad++;
         end
         if (locked && !prev_locked) begin
            rise_seen++;
            if (!rx_frame) rise_bad++;
         end
         prev_locked = locked;
      end
   end

   task automatic checkOutput(input string tag, input longint observed, input longint expected);
      checks++;
      assert (observed === expected) passed++;
      else begin
         fails++;
         $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
      end
   endtask

   // One raster line; hsync pulse sits two clocks before line end
   task automatic applyStimulus(input int line_len, input int de_len, input int vs_h, input int rst_h);
      for (int h = 0; h < line_len; h++) begin
         @(negedge clk_pix);
         if (rst_h >= 0 && h == rst_h) pre_locked = locked;
         if (rst_h >= 0 && h == rst_h + 1) snap = {rx_de, rx_x, rx_y, rx_frame, locked, err};
         rst_pix = (h == rst_h);
         de      = (h < de_len);
         hsync   = !((h >= line_len - 3) && (h < line_len - 1));
         vsync   = !((vs_h >= 0) && (h >= vs_h));
      end
   endtask

   task automatic sendFrame(input int nlines, input int stretch_line, input int long_line,
                            input int vs_h, input int rst_line, input int rst_h);
      for (int l = 0; l < nlines; l++) begin
         applyStimulus((l == stretch_line) ? HT + 1 : HT,
                       (l < VA) ? ((l == long_line) ? HT - 1 : HA) : 0,
                       (l == 4) ? vs_h : -1,
                       (l == rst_line) ? rst_h : -1);
      end
   endtask

   task automatic normalFrame();
      sendFrame(VT, -1, -1, 0, -1, -1);
   endtask

   task automatic doReset(input int n);
      @(negedge clk_pix);
      rst_pix = 1'b1; hsync = 1'b1; vsync = 1'b1; de = 1'b0;
      repeat (n) @(negedge clk_pix);
      rst_pix = 1'b0;
   endtask

   initial begin
      rst_pix = 1'b0; hsync = 1'b1; vsync = 1'b1; de = 1'b0;

      doReset(3);
      checkOutput("rst_rx_de", rx_de, 0);
      checkOutput("rst_rx_x", rx_x, 0);
      checkOutput("rst_rx_y", rx_y, 0);
      checkOutput("rst_rx_frame", rx_frame, 0);
      checkOutput("rst_locked", locked, 0);
      checkOutput("rst_err", err, 0);
      mon_en = 1;

      normalFrame(); checkOutput("a_f1_locked", locked, 0);
      normalFrame(); checkOutput("a_f2_locked", locked, 0);
      normalFrame(); checkOutput("a_f3_locked", locked, 1);
      checkOutput("a_err_count", err_seen, 0);
      checkOutput("a_frames", frames_seen, 3);
      checkOutput("a_max_x", max_x, HA - 1);
      checkOutput("a_max_y", max_y, VA - 1);

      e0 = err_seen;
      sendFrame(VT, 2, -1, 0, -1, -1);
      checkOutput("b_stretch_locked", locked, 0);
      checkOutput("b_stretch_err", err_seen - e0, 1);
      normalFrame(); checkOutput("b_relock1", locked, 0);
      normalFrame(); checkOutput("b_relock2", locked, 1);

      e0 = err_seen;
      sendFrame(VT - 1, -1, -1, 0, -1, -1);
      checkOutput("c_short_locked", locked, 1);
      normalFrame();
      checkOutput("c_next_locked", locked, 0);
      checkOutput("c_err", err_seen - e0, 1);
`ifdef VGA_SYNC_DECODER_STATS_EN
      checkOutput("c_v_meas", v_meas_o, VT - 1);
`endif
      normalFrame(); checkOutput("c_relock1", locked, 0);
      normalFrame(); checkOutput("c_relock2", locked, 1);

      e0 = err_seen;
      max_x = 0;
      sendFrame(VT, -1, 1, 0, -1, -1);
      checkOutput("d_long_de_locked", locked, 0);
      checkOutput("d_long_de_err", err_seen - e0, 1);
      checkOutput("d_long_de_max_x", max_x, HT - 2);
      normalFrame(); checkOutput("d_relock1", locked, 0);
      normalFrame(); checkOutput("d_relock2", locked, 1);

      e0 = err_seen;
      sendFrame(VT, -1, -1, 0, 1, 3);
      checkOutput("e_pre_locked", pre_locked, 1);
      checkOutput("e_outputs_after_reset", snap, 0);
      checkOutput("e_frame_locked", locked, 0);
      normalFrame(); checkOutput("e_relock1", locked, 0);
      normalFrame(); checkOutput("e_relock2", locked, 1);
      checkOutput("e_err", err_seen - e0, 0);

      e0 = err_seen;
      doReset(2);
      checkOutput("f_reset_locked", locked, 0);
      sendFrame(VT, -1, -1, 9, -1, -1); checkOutput("f_sim1_locked", locked, 0);
      sendFrame(VT, -1, -1, 9, -1, -1); checkOutput("f_sim2_locked", locked, 0);
      sendFrame(VT, -1, -1, 9, -1, -1); checkOutput("f_sim3_locked", locked, 1);
      sendFrame(VT, -1, -1, 9, -1, -1); checkOutput("f_sim4_locked", locked, 1);
      checkOutput("f_err", err_seen - e0, 0);
`ifdef VGA_SYNC_DECODER_STATS_EN
      checkOutput("f_v_meas", v_meas_o, VT);
      checkOutput("f_h_meas", h_meas_o, HT);
`endif

      checkOutput("total_err", err_seen, 3);
      checkOutput("total_frames", frames_seen, 20);
      checkOutput("total_lock_rises", rise_seen, 6);
      checkOutput("rx_de_latency", de_bad, 0);
      checkOutput("rx_frame_latency", fr_bad, 0);
      checkOutput("rx_xy_values", xy_bad, 0);
      checkOutput("err_with_lock_fall", errlock_bad, 0);
      checkOutput("lock_rise_with_frame", rise_bad, 0);
      checkOutput("max_y_total", max_y, VA - 1);

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule

// File: doc/vga_sync_decoder.md
# vga_sync_decoder

Receive-side counterpart of the 480p display timing generator. Watches an incoming hsync/vsync/de stream on the pixel clock, measures line and frame lengths, locks to the expected 640x480 timing, and regenerates pixel coordinates for downstream capture, checker, or overlay logic. In loopback it sits directly on the timing generator outputs as a self-check of the VGA path.

## Interface
- `H_ACTIVE`, 640, active pixels per line
- `H_TOTAL`, 800, clocks per line
- `V_ACTIVE`, 480, active lines per frame
- `V_TOTAL`, 525, lines per frame
- `SYNC_POL`, 0, asserted level of hsync/vsync (0 = active-low)
- `LOCK_FRAMES`, 2, consecutive good frames required for lock (1..15)

- `clk_pix` in 1: pixel clock; all logic on rising edge
- `rst_pix` in 1: synchronous reset, active-high
- `hsync` in 1: horizontal sync, same clock domain
- `vsync` in 1: vertical sync
- `de` in 1: data enable, active-high
- `rx_de` out 1: registered de, aligned with `rx_x`/`rx_y`
- `rx_x` out 16: pixel index within active line
- `rx_y` out 16: active line index within frame
- `rx_frame` out 1: one-cycle pulse on each vsync asserting edge
- `locked` out 1: timing matches parameters
- `err` out 1: one-cycle pulse on any timing mismatch while `locked`

## Operation
- Input stage: `hsync`, `vsync`, `de` registered once; edges detected from that register and its one-cycle-delayed copy. Asserting edge = transition to `SYNC_POL` level.
- Line measurement: `h_cnt` (16b) increments every clock, saturates at 16'hFFFF. On hsync edge: `h_meas <= h_cnt + 1` (saturating), `h_cnt <= 0`. First hsync edge after reset sets `h_valid`; `h_meas` is ignored until `h_valid`.
- Frame measurement: `v_cnt` (16b, saturating) counts hsync edges. On vsync edge: `v_meas <= v_cnt + (hsync edge this cycle)`, `v_cnt <= 0`. Steady-state `v_meas == V_TOTAL` regardless of hsync/vsync phase.
- `line_bad` sticky flag set when `h_valid` and `h_meas != H_TOTAL` on an hsync edge, or `rx_x` would exceed `H_ACTIVE-1`; cleared on vsync edge after evaluation.
- State machine:
  - SEARCH: reset state. First vsync edge -> ALIGN, `good <= 0`.
  - ALIGN: on each vsync edge, frame good iff `!line_bad && v_meas == V_TOTAL`. Good: `good <= good+1`; reaching `LOCK_FRAMES` -> LOCKED. Bad: `good <= 0`, stay.
  - LOCKED: any mismatch (line mismatch at hsync edge, or bad `v_meas` at vsync edge) -> `err` pulse, ALIGN, `good <= 0`.
- Coordinates: `rx_x` clears to 0 on de rising edge, +1 each de-high cycle after. `rx_y` clears to 0 on vsync edge; +1 on each de falling edge. Both saturate at 16'hFFFF. `rx_y` beyond `V_ACTIVE-1` counts as a mismatch.
- Simultaneous hsync and vsync edge: hsync evaluation first, then frame evaluation with that line included; one `err` pulse max per cycle.
- `rx_frame` fires on every vsync edge in any state.

## Timing
- Input to `rx_de`/`rx_x`/`rx_y`/`rx_frame`: 2 `clk_pix` cycles.
- `locked` rises 1 cycle after the qualifying vsync edge is detected; falls the same cycle `err` pulses.
- Reset values: `rx_de`=0, `rx_x`=0, `rx_y`=0, `rx_frame`=0, `locked`=0, `err`=0; internal counters 0, `h_valid`=0, state SEARCH.
- `rst_pix` mid-frame: all outputs to reset values next cycle; relock requires a fresh vsync edge plus `LOCK_FRAMES` good frames.

## Configuration
- `VGA_SYNC_DECODER_STATS_EN` defined: adds outputs `h_meas_o` (16), `v_meas_o` (16) holding last captured measurements, and `err_cnt` (16, saturating count of `err` pulses, reset 0).
- Not defined: ports and logic absent; core behaviour identical.

## Test plan
- Loopback from 480p timing generator, 3 frames after reset -> `locked` rises after 2nd full frame; `err` never pulses; `rx_x` 0..639, `rx_y` 0..479.
- In LOCKED, one line stretched to 801 clocks -> single `err` pulse at next hsync edge, `locked` low, relock after 2 good frames.
- Frame of 524 lines -> `err` at vsync edge, `v_meas_o`=524 (stats build).
- hsync and vsync asserting edges in the same cycle every frame -> `v_meas`=525, no `err`.
- `rst_pix` asserted mid-line for 1 cycle while locked -> all outputs 0 next cycle, state SEARCH, relock after vsync + 2 frames.
- de held high for 700 clocks -> mismatch flagged, `rx_x` reaches 699 without wrapping, `err` pulses once.
